// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one halfword read at a time and
// buffers fetched words with their PCs for the decode stage over a valid/ready handshake.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_mem_req,
  output logic [31:0]              o_mem_addr,
  input  logic                     i_mem_ack,
  input  logic [15:0]              i_mem_data,
  output logic                     o_valid,
  output logic [15:0]              o_ir,
  output logic [31:0]              o_pc,
  input  logic                     i_ready,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  typedef struct packed {
    logic [15:0] ir;
    logic [31:0] pc;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        head_q, head_d;
  entry_t        fifo_q [DEPTH];

  logic          ack, push, pop;
  logic [CW-1:0] remain;
  logic [31:0]   redirect_pc_even;
  logic [31:0]   next_pc;
  entry_t        push_entry;
  logic          unused_redirect_pc_bit0;

  assign unused_redirect_pc_bit0 = i_redirect_pc[0];
  assign redirect_pc_even        = {i_redirect_pc[31:1], 1'b0};
  assign ack                     = req_q && i_mem_ack;
  assign push                    = (state_q == REQ) && ack && !i_redirect;
  assign pop                     = (count_q != '0) && i_ready;
  assign push_entry              = '{ir: i_mem_data, pc: addr_q};
  assign remain                  = count_q - CW'(pop);

  // FIFO bookkeeping; a redirect clears the queue regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (i_redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = remain + CW'(push);
      // The head register is refreshed ahead of time so outputs never depend on inputs.
      if (count_d != '0) begin
        if (remain == '0) head_d = push_entry;
        else              head_d = fifo_q[rd_ptr_d];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rpc_d   = rpc_q;
    next_pc = pc_q;
    case (state_q)
      IDLE: begin
        if (i_redirect) begin
          pc_d = redirect_pc_even;
        end else if (count_q < CW'(DEPTH)) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          next_pc = i_redirect ? redirect_pc_even : addr_q + 32'd2;
          pc_d    = next_pc;
          addr_d  = next_pc;
          if (count_d < CW'(DEPTH)) begin
            state_d = REQ;
            req_d   = 1'b1;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (i_redirect) begin
          state_d = DISCARD;
          rpc_d   = redirect_pc_even;
        end
      end
      DISCARD: begin
        // The stale request must still complete; its data is dropped.
        if (ack) begin
          next_pc = i_redirect ? redirect_pc_even : rpc_q;
          pc_d    = next_pc;
          addr_d  = next_pc;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (i_redirect) begin
          rpc_d = redirect_pc_even;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      rpc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      rpc_q    <= rpc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage array has no reset; entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  assign o_mem_req  = req_q;
  assign o_mem_addr = addr_q;
  assign o_valid    = (count_q != '0);
  assign o_ir       = head_q.ir;
  assign o_pc       = head_q.pc;
  assign o_count    = count_q;

endmodule
